// File: rtl/piso_shift_165.sv
// ---------------------------------------------------------------------------
// piso_shift_165
//   Parallel-in, serial-out shift register transmitter (74x165 style).
//   A WIDTH-bit word is captured on LOAD while idle and shifted out one bit
//   per clock. The vacated end of the register is filled from SER so that
//   several stages can be cascaded. INH freezes the shifter, counter and state.
//
// Parameters
//   WIDTH     word length in bits (>= 2)
//   MSB_FIRST 1: D[WIDTH-1] leaves first; 0: D[0] leaves first
//
// Ports
//   CLK    system clock, rising edge
//   RST    asynchronous active-high reset
//   D      parallel data word
//   LOAD   load request, accepted only while idle and not inhibited
//   SER    cascade serial input
//   INH    clock inhibit (holds everything while 1)
//   Q      serial data out (head bit of the register)
//   Q_N    complement of Q
//   READY  1 while idle and able to accept LOAD
//   DONE   one-cycle pulse after the last bit-time of a word
// ---------------------------------------------------------------------------
module piso_shift_165 #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD,
    input  logic             SER,
    input  logic             INH,
    output logic             Q,
    output logic             Q_N,
    output logic             READY,
    output logic             DONE
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    count;
    logic             done_r;

    // Next register contents for one shift toward the Q end, SER entering
    // the far end.
    always_comb begin
        shifted = shreg;
        if (MSB_FIRST) begin
            shifted = {shreg[WIDTH-2:0], SER};
        end else begin
            shifted = {SER, shreg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            shreg  <= '0;
            count  <= '0;
            done_r <= 1'b0;
        end else begin
            // DONE is a single-cycle pulse even when INH is asserted.
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (LOAD && !INH) begin
                        shreg <= D;
                        count <= CW'(WIDTH - 1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // LOAD is deliberately ignored here; it is not queued.
                    if (!INH) begin
                        shreg <= shifted;
                        if (count != '0) begin
                            count <= count - CW'(1);
                        end else begin
                            state  <= IDLE;
                            done_r <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Q     = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign Q_N   = ~Q;
    assign READY = (state == IDLE);
    assign DONE  = done_r;

endmodule

// File: tb/tb_piso_shift_165.sv
// ---------------------------------------------------------------------------
// tb_piso_shift_165
//   Drives an MSB-first and an LSB-first instance with identical stimulus.
//   The reference model treats each register as a queue of bits whose front
//   is the bit on Q; expected outputs are queued per clock edge and a
//   separate monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_piso_shift_165;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] D = '0;
    logic         LOAD = 1'b0;
    logic         SER = 1'b0;
    logic         INH = 1'b0;

    logic qm, qmn, rm, dm;
    logic ql, qln, rl, dl;

    piso_shift_165 #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .CLK(CLK), .RST(RST), .D(D), .LOAD(LOAD), .SER(SER), .INH(INH),
        .Q(qm), .Q_N(qmn), .READY(rm), .DONE(dm)
    );

    piso_shift_165 #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .CLK(CLK), .RST(RST), .D(D), .LOAD(LOAD), .SER(SER), .INH(INH),
        .Q(ql), .Q_N(qln), .READY(rl), .DONE(dl)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard of expected {qm,qmn,ql,qln,rm,dm,rl,dl}, one per edge.
    logic [7:0] sb[$];

    // Reference model: bits in transmit order, front = bit on Q.
    bit mq[$];
    bit lq[$];
    bit busy;
    int remaining;
    bit done_m;

    function automatic logic [7:0] actual();
        return {qm, qmn, ql, qln, rm, dm, rl, dl};
    endfunction

    function automatic logic [7:0] expected();
        return {mq[0], ~mq[0], lq[0], ~lq[0], ~busy, done_m, ~busy, done_m};
    endfunction

    function automatic void model_reset();
        mq.delete();
        lq.delete();
        for (int i = 0; i < W; i++) begin
            mq.push_back(1'b0);
            lq.push_back(1'b0);
        end
        busy      = 1'b0;
        remaining = 0;
        done_m    = 1'b0;
    endfunction

    function automatic void model_edge(bit ld, bit inh, bit ser, logic [W-1:0] d);
        bit nd;
        nd = 1'b0;
        if (!busy) begin
            if (ld && !inh) begin
                mq.delete();
                lq.delete();
                for (int i = 0; i < W; i++) begin
                    mq.push_back(d[W-1-i]);
                    lq.push_back(d[i]);
                end
                busy      = 1'b1;
                remaining = W;
            end
        end else if (!inh) begin
            void'(mq.pop_front());
            void'(lq.pop_front());
            mq.push_back(ser);
            lq.push_back(ser);
            remaining--;
            if (remaining == 0) begin
                busy = 1'b0;
                nd   = 1'b1;
            end
        end
        done_m = nd;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got {qm,qmn,ql,qln,rm,dm,rl,dl}=%b want %b",
                     name, $time, act, exp);
        end
    endtask

    // One clock: drive at falling edge, update model at rising edge.
    task automatic cyc(input bit rst, input bit ld, input logic [W-1:0] d,
                       input bit ser, input bit inh);
        @(negedge CLK);
        RST  = rst;
        LOAD = ld;
        D    = d;
        SER  = ser;
        INH  = inh;
        @(posedge CLK);
        if (rst) model_reset();
        else     model_edge(ld, inh, ser, d);
        sb.push_back(expected());
    endtask

    task automatic idle(input int n, input bit ser);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, ser, 1'b0);
    endtask

    // Reset asserted between edges must take effect before the next edge.
    task automatic mid_reset();
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("async_reset", actual(), 8'b0101_1010);
        @(posedge CLK);
        model_reset();
        sb.push_back(expected());
    endtask

    // Monitor
    initial begin
        @(negedge CLK);
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard_underflow t=%0t got %b want <entry>", $time, actual());
            end else begin
                chk("cycle", actual(), sb.pop_front());
            end
        end
    end

    // Stimulus
    initial begin
        model_reset();
        #7;
        chk("reset_state", actual(), 8'b0101_1010);

        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Basic word A5, SER=0
        cyc(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        idle(10, 1'b0);

        // Word 01 with SER=1 cascading in
        cyc(1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
        idle(10, 1'b1);

        // Inhibit for 3 cycles after bit 2
        cyc(1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        idle(2, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(8, 1'b0);

        // Inhibit blocks load while idle
        cyc(1'b0, 1'b1, 8'h81, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Back-to-back: next LOAD in the DONE cycle, then LOAD held high
        cyc(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
        idle(W, 1'b0);
        cyc(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < W + 3; i++) cyc(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
        idle(W + 2, 1'b0);

        // Ignored load of FF at bit 4 of word 00
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        idle(4, 1'b0);
        cyc(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        idle(6, 1'b0);

        // Reset mid-word, then a fresh word
        cyc(1'b0, 1'b1, 8'hB7, 1'b1, 1'b0);
        idle(3, 1'b1);
        mid_reset();
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h6D, 1'b0, 1'b0);
        idle(10, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                mid_reset();
                cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
            end else begin
                cyc(1'b0,
                    ($urandom_range(0, 3) == 0),
                    W'($urandom),
                    1'($urandom),
                    ($urandom_range(0, 5) == 0));
            end
        end

        // Let the monitor consume the final entry before the next edge.
        #2;
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
